// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, XLEN+1 edge latency.
// Optional one-entry result cache enabled by defining MULDIV_REUSE_EN.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_reg,
    output logic            wb_en
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   rs1_q, rs2_q;
    logic [2:0]        f3_q;
    logic              neg_a, neg_b;
    logic              hit;
    logic [XLEN-1:0]   hit_data;

    logic              a_signed, b_signed;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum, rem_sh, trial;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quo, rem, fin_lo, fin_hi, fix_data;

    // lo = MUL low half / quotient, hi = MULH* high half / remainder.
    function automatic logic [XLEN-1:0] sel_result(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] lo,
                                                   input logic [XLEN-1:0] hi);
        if (f3[2])
            return f3[1] ? hi : lo;
        return (f3[1:0] == 2'b00) ? lo : hi;
    endfunction

    // Issue-time operand conditioning.
    always_comb begin
        if (funct3[2]) begin
            a_signed = !funct3[0];
            b_signed = !funct3[0];
        end else begin
            a_signed = (funct3 == 3'b001) || (funct3 == 3'b010);
            b_signed = (funct3 == 3'b001);
        end
        abs_a = (a_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
        abs_b = (b_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
    end

    // One iteration: multiply keeps {partial sum, remaining multiplier}, divide keeps {remainder, quotient}.
    always_comb begin
        mul_sum  = acc[0] ? ({1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, op_b})
                          : {1'b0, acc[2*XLEN-1:XLEN]};
        mul_next = {mul_sum, acc[XLEN-1:1]};
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        trial    = rem_sh - {1'b0, op_b};
        div_next = trial[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    // Sign correction and the two forced divide cases.
    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quo  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (rs2_q == '0) begin
            quo = '1;
            rem = rs1_q;
        end else if (!f3_q[0] && rs1_q == {1'b1, {(XLEN-1){1'b0}}} && rs2_q == '1) begin
            quo = {1'b1, {(XLEN-1){1'b0}}};
            rem = '0;
        end
        fin_lo   = f3_q[2] ? quo : prod[XLEN-1:0];
        fin_hi   = f3_q[2] ? rem : prod[2*XLEN-1:XLEN];
        fix_data = sel_result(f3_q, fin_lo, fin_hi);
    end

`ifdef MULDIV_REUSE_EN
    typedef enum logic [2:0] {C_MULH, C_MULHSU, C_MULU, C_DIV, C_DIVU} cls_t;

    function automatic cls_t cls_of(input logic [2:0] f3);
        if (f3[2])
            return f3[0] ? C_DIVU : C_DIV;
        case (f3[1:0])
            2'b01:   return C_MULH;
            2'b10:   return C_MULHSU;
            default: return C_MULU;
        endcase
    endfunction

    logic            c_valid;
    logic [XLEN-1:0] c_rs1, c_rs2, c_lo, c_hi;
    cls_t            c_cls;

    assign hit = c_valid && (c_rs1 == rs1_data) && (c_rs2 == rs2_data) && (c_cls == cls_of(funct3));
    assign hit_data = sel_result(funct3, c_lo, c_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_rs1   <= '0;
            c_rs2   <= '0;
            c_lo    <= '0;
            c_hi    <= '0;
            c_cls   <= C_MULU;
        end else if (state == S_FIX) begin
            c_valid <= 1'b1;
            c_rs1   <= rs1_q;
            c_rs2   <= rs2_q;
            c_lo    <= fin_lo;
            c_hi    <= fin_hi;
            c_cls   <= cls_of(f3_q);
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = hit ? S_DONE : S_CALC;
            S_CALC: if (cnt == CW'(XLEN-1)) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign wb_en = done && (wb_reg != 5'd0);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            op_b    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            f3_q    <= '0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            wb_data <= '0;
            wb_reg  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    rs1_q   <= rs1_data;
                    rs2_q   <= rs2_data;
                    f3_q    <= funct3;
                    wb_reg  <= rd_addr;
                    neg_a   <= a_signed && rs1_data[XLEN-1];
                    neg_b   <= b_signed && rs2_data[XLEN-1];
                    op_b    <= abs_b;
                    acc     <= {{XLEN{1'b0}}, abs_a};
                    cnt     <= '0;
                    if (hit)
                        wb_data <= hit_data;
                end
                S_CALC: begin
                    acc <= f3_q[2] ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                end
                S_FIX:   wb_data <= fix_data;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; latency is counted in edges after the issue edge.
// Cache-dependent expectations follow MULDIV_REUSE_EN.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy, done, wb_en;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;

    int total = 0;
    int bad   = 0;

`ifdef MULDIV_REUSE_EN
    localparam int HIT_EDGE = 0;
`else
    localparam int HIT_EDGE = 33;
`endif

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .busy(busy), .done(done), .wb_data(wb_data), .wb_reg(wb_reg), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one op, waits (bounded) for done, returns the done edge offset and write-back fields.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int edge_n, output logic [31:0] data,
                          output logic [4:0] rg, output logic en);
        funct3 = f3; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        edge_n = 0;
        while (!done && edge_n < 100) begin
            @(posedge clk); #1;
            edge_n++;
        end
        data = wb_data; rg = wb_reg; en = wb_en;
        check("done_seen", 64'(done), 64'd1);
        check("busy_during_done", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int          e;
        int          n_done;
        int          k;
        logic [31:0] d;
        logic [4:0]  r;
        logic        en;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wb_en", 64'(wb_en), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_wb_reg", 64'(wb_reg), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, e, d, r, en);
        check("mul_latency", 64'(e), 64'd33);
        check("mul_data", 64'(d), 64'hFFFF_FFEB);
        check("mul_reg", 64'(r), 64'd5);
        check("mul_wb_en", 64'(en), 64'd1);
        check("mul_wb_en_drop", 64'(wb_en), 64'd0);

        // Each op starts the cycle after the previous done: back-to-back issue.
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, e, d, r, en);
        check("mulhu_data", 64'(d), 64'hFFFF_FFFE);
        check("mulhu_latency", 64'(e), 64'd33);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, e, d, r, en);
        check("mulh_data", 64'(d), 64'h0);
        check("mulh_latency", 64'(e), 64'd33);
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, e, d, r, en);
        check("mulhsu_data", 64'(d), 64'hFFFF_FFFF);

        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, e, d, r, en);
        check("div_ovf_quo", 64'(d), 64'h8000_0000);
        check("div_ovf_latency", 64'(e), 64'd33);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, e, d, r, en);
        check("rem_ovf", 64'(d), 64'h0);
        run_op(3'b101, 32'd5, 32'd0, 5'd6, e, d, r, en);
        check("divu_by0", 64'(d), 64'hFFFF_FFFF);
        check("divu_by0_latency", 64'(e), 64'd33);
        run_op(3'b111, 32'd5, 32'd0, 5'd6, e, d, r, en);
        check("remu_by0", 64'(d), 64'd5);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8, e, d, r, en);
        check("div_neg", 64'(d), 64'hFFFF_FFFD);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, e, d, r, en);
        check("rem_neg", 64'(d), 64'hFFFF_FFFF);

        run_op(3'b000, 32'd9, 32'd9, 5'd0, e, d, r, en);
        check("rd0_data", 64'(d), 64'd81);
        check("rd0_wb_en", 64'(en), 64'd0);

        // Start during CALC with changed inputs: ignored, one done, original result.
        funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd4; rd_addr = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        funct3 = 3'b101; rs1_data = 32'd99; rs2_data = 32'd11; rd_addr = 5'd9;
        repeat (5) @(posedge clk);
        #1;
        check("busy_in_calc", 64'(busy), 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 6; n_done = 0; e = -1; d = '0; r = '0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                n_done++; e = k; d = wb_data; r = wb_reg;
            end
            @(posedge clk); #1;
            k++;
        end
        check("ignored_start_one_done", 64'(n_done), 64'd1);
        check("ignored_start_edge", 64'(e), 64'd33);
        check("ignored_start_data", 64'(d), 64'd12);
        check("ignored_start_reg", 64'(r), 64'd7);

        // Reset at edge N+10 aborts with no write-back.
        funct3 = 3'b000; rs1_data = 32'd5; rs2_data = 32'd5; rd_addr = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || wb_en) n_done++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        run_op(3'b000, 32'd6, 32'd7, 5'd4, e, d, r, en);
        check("post_abort_data", 64'(d), 64'd42);
        check("post_abort_latency", 64'(e), 64'd33);

        run_op(3'b100, 32'd100, 32'd7, 5'd10, e, d, r, en);
        check("div100_7", 64'(d), 64'd14);
        check("div100_7_latency", 64'(e), 64'd33);
        run_op(3'b110, 32'd100, 32'd7, 5'd11, e, d, r, en);
        check("rem100_7", 64'(d), 64'd2);
        check("rem100_7_latency", 64'(e), 64'(HIT_EDGE));
        check("rem100_7_reg", 64'(r), 64'd11);
        run_op(3'b101, 32'd100, 32'd7, 5'd12, e, d, r, en);
        check("divu100_7", 64'(d), 64'd14);
        check("divu100_7_latency", 64'(e), 64'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
